// File: rtl/lcd_bus_driver.sv
// HD44780 bus sequencer: turns a toggle-request write of the LCD register into a
// timed setup / EN pulse / hold / execution-wait cycle with busy and done status.
module lcd_bus_driver #(
    parameter int T_SETUP     = 4,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int CNT_W       = 17
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_io_lcd,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             req_q;
    logic             long_q;
    logic             req;
    logic             unused_bits;

    // A request is any change of the toggle bit relative to the last accepted value.
    assign req         = i_io_lcd[10] ^ req_q;
    assign unused_bits = ^{i_io_lcd[30:11], i_io_lcd[8]};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            timer      <= '0;
            req_q      <= 1'b0;
            long_q     <= 1'b0;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_rw   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_lcd_on <= i_io_lcd[31];
            o_lcd_rw <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        req_q      <= i_io_lcd[10];
                        o_lcd_rs   <= i_io_lcd[9];
                        o_lcd_data <= i_io_lcd[7:0];
                        // Clear display (0x01) and return home (0x02/0x03) need the long wait.
                        long_q     <= !i_io_lcd[9] && (i_io_lcd[7:2] == 6'd0)
                                      && (i_io_lcd[1:0] != 2'd0);
                        o_busy     <= 1'b1;
                        timer      <= LD_SETUP;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (timer == '0) begin
                        timer    <= LD_PULSE;
                        o_lcd_en <= 1'b1;
                        state    <= PULSE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                PULSE: begin
                    if (timer == '0) begin
                        timer    <= LD_HOLD;
                        o_lcd_en <= 1'b0;
                        state    <= HOLD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        timer <= long_q ? LD_LONG : LD_EXEC;
                        state <= WAIT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WAIT: begin
                    if (timer == '0) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
